tt_dfd_clkgate_ctrl: RTL and testbench
======================================

Name: tt_dfd_clkgate_ctrl

Overview:
- Parametrised, multi-channel clock-gating controller. Successor to the single-channel generic clock gate.
- Each of NUM_CH channels gets its own gated clock from a latch-based gate cell.
- The gate enable comes from a per-channel activity FSM with programmable hysteresis (hold-off) counting, plus force-on, global-bypass and test-enable overrides.
- Sits between DFD sub-blocks (trace, debug-bus, counters) and their clock roots; lets idle DFD logic stop clocking without losing the first active cycle.

Parameters:
- NUM_CH, 4, number of independently gated channels (1..32).
- HYST_W, 4, width of the hysteresis count; hold-off range 0..2^HYST_W-1 cycles.

Ports:
- clk  input  1  free-running source clock.
- reset  input  1  asynchronous, active-high reset.
- te  input  1  scan/test enable; forces all gates open.
- cfg_gate_en  input  1  global gating enable; 0 = all channels ungated (bypass).
- cfg_hyst  input  HYST_W  hold-off cycles after activity ends; shared by all channels.
- cfg_force_on  input  NUM_CH  per-channel force-open.
- req  input  NUM_CH  per-channel wake request (pulse or level).
- busy  input  NUM_CH  per-channel busy level from the clocked logic.
- clk_out  output  NUM_CH  per-channel gated clocks.
- ch_en  output  NUM_CH  registered copy of each channel's gate enable (status).
- ch_wake  output  NUM_CH  one-cycle pulse on each IDLE->RUN transition.

Behaviour:
- Per channel, act[i] = req[i] | busy[i].
- FSM states: IDLE, RUN, HOLD. Hold counter cnt is HYST_W bits.
  - Any state, act=1 -> RUN; cnt := cfg_hyst.
  - RUN, act=0: cnt==0 -> IDLE; else -> HOLD with cnt := cnt-1.
  - HOLD, act=0: cnt==0 -> IDLE; else stay HOLD with cnt := cnt-1.
  - IDLE, act=0: stay IDLE.
- Gate enable (combinational): en[i] = act[i] | (state!=IDLE & cnt!=0) | cfg_force_on[i] | ~cfg_gate_en | reset.
- en[i] feeds the gate cell's en input; te feeds the cell's te input.
- Wake latency: zero. A request asserted while clk is low opens the gate for the very next rising edge. req/busy must come from clk-domain flops; no synchronisers inside.
- Hysteresis: after the last cycle with act=1, clk_out[i] pulses for exactly cfg_hyst further cycles, then stops. cfg_hyst=0 gates on the first idle cycle.
- Re-activation during HOLD returns the channel to RUN and reloads cnt; no gated cycle is inserted.
- A cfg_hyst change mid-HOLD does not affect the running cnt; it takes effect on the next reload.
- Overrides (force, bypass, te) keep the gate open but do not stop the FSM. Removing an override gates immediately if the FSM is IDLE.
- During reset the gate is held open so downstream flops see clock edges.
  - FSM -> IDLE, cnt -> 0, ch_en -> 0, ch_wake -> 0, all asynchronously.
  - Reset mid-HOLD abandons the count.
- ch_en[i] <= en[i] each cycle; one-cycle lag; status only.
- ch_wake[i] is a registered pulse the cycle after the IDLE->RUN transition. It does not fire on HOLD->RUN.
- Counters never wrap: decrement happens only when cnt!=0.

Decomposition:
- Package tt_dfd_clkgate_pkg holds:
  - the enum type for state (IDLE=2'd0, RUN=2'd1, HOLD=2'd2);
  - the localparam for max NUM_CH.
- Sub-module tt_dfd_clkgate_ch:
  - contains one channel's FSM, counter, enable logic, ch_en/ch_wake flops and one tt_dfd_generic_clkgate instance;
  - the top is a generate loop over NUM_CH.

Test Plan:
- Reset: assert reset with all inputs 0 -> clk_out toggles on every channel during reset; after release ch_en=0, ch_wake=0, and clk_out stays low with req=0.
- Basic hysteresis: cfg_gate_en=1, cfg_hyst=3, req[0] high for 1 cycle -> clk_out[0] gives 1+3 = 4 rising edges, then stays low; ch_wake[0] pulses once; other channels silent.
- Zero hold-off: cfg_hyst=0, busy[1] high for 5 cycles -> exactly 5 edges on clk_out[1]; ch_en[1] = 1 for 5 cycles, lagging by 1.
- Re-wake in HOLD: cfg_hyst=4, req[2] pulse, second pulse 2 cycles later -> continuous clocking with no gap; total 1+2+1+4 edges; ch_wake[2] pulses only once.
- Overrides: cfg_force_on[3]=1 -> clk_out[3] free-runs; drop force while IDLE -> gated the next cycle. Separately, te=1 or cfg_gate_en=0 -> all channels free-run.
- Reset mid-HOLD: cfg_hyst=15, req[0] pulse, reset after 5 cycles -> FSM IDLE, clk open while reset is high; after release, no residual hold edges.

Source files
------------

// File: rtl/tt_dfd_clkgate_pkg.sv
// Shared types and limits for the multi-channel DFD clock-gating controller.
package tt_dfd_clkgate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } clkgate_state_e;

  localparam int MAX_NUM_CH = 32;

endpackage

// File: rtl/tt_dfd_clkgate_ch.sv
// One gated-clock channel: activity FSM with hold-off counter, override
// logic, status flops and the gate cell.
//
// state   | meaning
// IDLE    | no activity, hold-off expired; gate closed unless overridden
// RUN     | req/busy seen on the last edge; cnt loaded with cfg_hyst
// HOLD    | activity ended; gate stays open while cnt != 0
module tt_dfd_clkgate_ch
  import tt_dfd_clkgate_pkg::*;
#(
  parameter int HYST_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              te,
  input  logic              cfg_gate_en,
  input  logic [HYST_W-1:0] cfg_hyst,
  input  logic              force_on,
  input  logic              req,
  input  logic              busy,
  output logic              clk_out,
  output logic              ch_en,
  output logic              ch_wake
);

  clkgate_state_e    state_q, state_d;
  logic [HYST_W-1:0] cnt_q, cnt_d;
  logic              ch_en_q, ch_wake_q;
  logic              act, en, wake_d;

  assign act = req | busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (act) begin
      state_d = ST_RUN;
      cnt_d   = cfg_hyst;
    end else begin
      case (state_q)
        ST_RUN, ST_HOLD: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = cnt_q - HYST_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign wake_d = act & (state_q == ST_IDLE);

  // Reset keeps the gate open so downstream flops still see edges.
  assign en = act | ((state_q != ST_IDLE) && (cnt_q != '0)) | force_on
            | ~cfg_gate_en | reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ch_en_q   <= 1'b0;
      ch_wake_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_en_q   <= en;
      ch_wake_q <= wake_d;
    end
  end

  assign ch_en   = ch_en_q;
  assign ch_wake = ch_wake_q;

  tt_dfd_generic_clkgate u_gate (
    .clk     (clk),
    .en      (en),
    .te      (te),
    .clk_out (clk_out)
  );

endmodule

// File: rtl/tt_dfd_generic_clkgate.sv
// Latch-based clock gate: enable is captured while clk is low, so clk_out
// can never glitch during the high phase.
module tt_dfd_generic_clkgate (
  input  logic clk,
  input  logic en,
  input  logic te,
  output logic clk_out
);

  logic en_lat;

  always_latch begin
    if (!clk) en_lat <= en | te;
  end

  assign clk_out = clk & en_lat;

endmodule

// File: rtl/tt_dfd_clkgate_ctrl.sv
// Multi-channel DFD clock-gating controller: one independent gated clock
// per channel, sharing the hold-off setting and global overrides.
module tt_dfd_clkgate_ctrl
  import tt_dfd_clkgate_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int HYST_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              te,
  input  logic              cfg_gate_en,
  input  logic [HYST_W-1:0] cfg_hyst,
  input  logic [NUM_CH-1:0] cfg_force_on,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] ch_wake
);

  if (NUM_CH < 1 || NUM_CH > MAX_NUM_CH) begin : g_bad_num_ch
    $error("tt_dfd_clkgate_ctrl: NUM_CH out of range");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tt_dfd_clkgate_ch #(
      .HYST_W (HYST_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .te          (te),
      .cfg_gate_en (cfg_gate_en),
      .cfg_hyst    (cfg_hyst),
      .force_on    (cfg_force_on[i]),
      .req         (req[i]),
      .busy        (busy[i]),
      .clk_out     (clk_out[i]),
      .ch_en       (ch_en[i]),
      .ch_wake     (ch_wake[i])
    );
  end

endmodule

// File: tb/tb_tt_dfd_clkgate_ctrl.sv
// Self-checking bench for tt_dfd_clkgate_ctrl: directed test-plan steps then
// random traffic, against a "last activity + hold window" reference model.
module tb_tt_dfd_clkgate_ctrl;

  localparam int NUM_CH = 4;
  localparam int HYST_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              te;
  logic              cfg_gate_en;
  logic [HYST_W-1:0] cfg_hyst;
  logic [NUM_CH-1:0] cfg_force_on;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] ch_wake;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_act[NUM_CH];
  int hload[NUM_CH];
  int edges[NUM_CH];
  int wakes[NUM_CH];

  tt_dfd_clkgate_ctrl #(
    .NUM_CH (NUM_CH),
    .HYST_W (HYST_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .te           (te),
    .cfg_gate_en  (cfg_gate_en),
    .cfg_hyst     (cfg_hyst),
    .cfg_force_on (cfg_force_on),
    .req          (req),
    .busy         (busy),
    .clk_out      (clk_out),
    .ch_en        (ch_en),
    .ch_wake      (ch_wake)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [NUM_CH-1:0] obs,
                           input logic [NUM_CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NUM_CH; i++) begin
      edges[i] = 0;
      wakes[i] = 0;
    end
  endtask

  // One clock cycle. Inputs are already set; the model decides, per channel,
  // whether the upcoming edge is passed, then DUT outputs are compared.
  task automatic tick();
    logic [NUM_CH-1:0] act, exp_clk, exp_en, exp_wake;
    bit idle, hold_open, e;
    act = req | busy;
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        exp_clk[i]  = 1'b1;
        exp_en[i]   = 1'b0;
        exp_wake[i] = 1'b0;
      end else begin
        // A channel stays open for hload cycles after its last active cycle;
        // it is only back to idle one cycle after the window runs out.
        hold_open   = (last_act[i] >= 0) && (cyc - last_act[i] <= hload[i]);
        idle        = (last_act[i] < 0) || (cyc - last_act[i] >= hload[i] + 2);
        e           = act[i] | hold_open | cfg_force_on[i] | ~cfg_gate_en;
        exp_clk[i]  = e | te;
        exp_en[i]   = e;
        exp_wake[i] = act[i] & idle;
      end
    end
    @(negedge clk);
    #1;
    check_vec("clk_out_low", clk_out, '0);
    @(posedge clk);
    #1;
    check_vec("clk_out", clk_out, exp_clk);
    check_vec("ch_en", ch_en, exp_en);
    check_vec("ch_wake", ch_wake, exp_wake);
    for (int i = 0; i < NUM_CH; i++) begin
      if (clk_out[i]) edges[i]++;
      if (ch_wake[i]) wakes[i]++;
      if (reset) begin
        last_act[i] = -1;
      end else if (act[i]) begin
        last_act[i] = cyc;
        hload[i]    = int'(cfg_hyst);
      end
    end
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      last_act[i] = -1;
      hload[i]    = 0;
    end
    clear_counts();
    reset        = 1'b1;
    te           = 1'b0;
    cfg_gate_en  = 1'b1;
    cfg_hyst     = '0;
    cfg_force_on = '0;
    req          = '0;
    busy         = '0;

    // Reset: gates open, status cleared; then everything gated.
    repeat (3) tick();
    check_int("reset_edges_ch0", edges[0], 3);
    reset = 1'b0;
    clear_counts();
    repeat (3) tick();
    check_int("post_reset_edges_ch3", edges[3], 0);

    // Basic hysteresis: 1 active + 3 hold edges.
    cfg_hyst = 4'd3;
    clear_counts();
    req = 4'b0001;
    tick();
    req = '0;
    repeat (7) tick();
    check_int("hyst3_edges", edges[0], 4);
    check_int("hyst3_wakes", wakes[0], 1);
    check_int("hyst3_other", edges[1] + edges[2] + edges[3], 0);

    // Zero hold-off with busy level.
    cfg_hyst = 4'd0;
    clear_counts();
    busy = 4'b0010;
    repeat (5) tick();
    busy = '0;
    repeat (3) tick();
    check_int("hyst0_edges", edges[1], 5);

    // Re-wake during HOLD, plus a hyst change that must not affect the count.
    cfg_hyst = 4'd4;
    clear_counts();
    req = 4'b0100;
    tick();
    req = '0;
    repeat (2) tick();
    req = 4'b0100;
    tick();
    req = '0;
    cfg_hyst = 4'd9;
    repeat (8) tick();
    check_int("rewake_edges", edges[2], 8);
    check_int("rewake_wakes", wakes[2], 1);

    // Overrides.
    cfg_hyst = 4'd0;
    clear_counts();
    cfg_force_on = 4'b1000;
    repeat (3) tick();
    cfg_force_on = '0;
    repeat (2) tick();
    check_int("force_edges", edges[3], 3);
    te = 1'b1;
    repeat (2) tick();
    te = 1'b0;
    cfg_gate_en = 1'b0;
    repeat (2) tick();
    cfg_gate_en = 1'b1;
    repeat (2) tick();

    // Reset mid-HOLD abandons the count.
    cfg_hyst = 4'd15;
    req = 4'b0001;
    tick();
    req = '0;
    repeat (5) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    clear_counts();
    repeat (4) tick();
    check_int("reset_midhold_edges", edges[0], 0);

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      req  = NUM_CH'($urandom & $urandom & $urandom);
      busy = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom & $urandom) : '0;
      if ($urandom_range(0, 15) == 0) cfg_hyst = HYST_W'($urandom);
      cfg_force_on = ($urandom_range(0, 19) == 0) ? NUM_CH'($urandom) : '0;
      te           = ($urandom_range(0, 29) == 0);
      cfg_gate_en  = ($urandom_range(0, 29) != 0);
      reset        = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
